// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - button debouncer sample/level bundle
// Grouped sampling inputs and debounced outputs shared by the debouncer and its driver.
interface button_debounce_if #(
  parameter int N_BTN = 5
);
  logic             clk_deb;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             sample_tick;

  modport master (
    output clk_deb,
    output btn_in,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  sample_tick
  );

  modport slave (
    input  clk_deb,
    input  btn_in,
    output btn_state,
    output btn_press,
    output btn_release,
    output sample_tick
  );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - multi-channel push-button debouncer
// Samples synchronized buttons on each clk_deb rising edge and accepts a level after STABLE_CNT agreeing samples.
module button_debounce #(
  parameter int N_BTN      = 5,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  button_debounce_if.slave deb
);
  localparam int            CW       = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [N_BTN-1:0] btn_meta_q;
  logic [N_BTN-1:0] btn_sync_q;
  logic             deb_meta_q;
  logic             deb_sync_q;
  logic             deb_hist_q;
  logic             tick_q;
  logic             tick_d;
  logic [N_BTN-1:0] state_q;
  logic [N_BTN-1:0] state_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] release_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  // clk_deb is only data here: a rising edge seen after synchronization becomes a one-clk strobe
  assign tick_d = deb_sync_q & ~deb_hist_q;

  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q) begin
        if (btn_sync_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]     = '0;
          state_d[i]   = btn_sync_q[i];
          press_d[i]   = btn_sync_q[i];
          release_d[i] = ~btn_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      deb_meta_q <= 1'b0;
      deb_sync_q <= 1'b0;
      deb_hist_q <= 1'b0;
      tick_q     <= 1'b0;
      state_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      btn_meta_q <= deb.btn_in;
      btn_sync_q <= btn_meta_q;
      deb_meta_q <= deb.clk_deb;
      deb_sync_q <= deb_meta_q;
      deb_hist_q <= deb_sync_q;
      tick_q     <= tick_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign deb.btn_state   = state_q;
  assign deb.btn_press   = press_q;
  assign deb.btn_release = release_q;
  assign deb.sample_tick = tick_q;
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of independent push-button channels.
REQ-002 SHALL have parameter STABLE_CNT, default 4, consecutive agreeing samples required to accept a new level; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, system clock; sole clock, all flops on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clk_deb, input, 1, divided sample-rate square wave from the debounce divider; treated as data, never as a clock.
REQ-006 SHALL have port btn_in, input, N_BTN, raw asynchronous button levels, active-high.
REQ-007 SHALL have port btn_state, output, N_BTN, debounced button levels.
REQ-008 SHALL have port btn_press, output, N_BTN, one-clk pulse per channel on accepted 0->1.
REQ-009 SHALL have port btn_release, output, N_BTN, one-clk pulse per channel on accepted 1->0.
REQ-010 SHALL have port sample_tick, output, 1, one-clk strobe marking each sample instant.

Function
REQ-011 SHALL pass each btn_in bit through a 2-flop synchronizer; the second stage is the sampled raw value.
REQ-012 SHALL pass clk_deb through a 2-flop synchronizer plus one history flop; sample_tick = 1 for exactly one clk when synced value is 1 and history is 0.
REQ-013 SHALL assert sample_tick once per clk_deb period; clk_deb falling edges produce no tick.
REQ-014 SHALL keep, per channel, a counter of width ceil(log2(STABLE_CNT+1)), no wrap beyond STABLE_CNT-1.
REQ-015 SHALL evaluate channels only on cycles with sample_tick = 1; all counters and states hold otherwise.
REQ-016 On tick, raw == btn_state[i]: cnt[i] SHALL clear to 0.
REQ-017 On tick, raw != btn_state[i] and cnt[i] < STABLE_CNT-1: cnt[i] SHALL increment.
REQ-018 On tick, raw != btn_state[i] and cnt[i] == STABLE_CNT-1: btn_state[i] SHALL take raw, cnt[i] SHALL clear to 0.
REQ-019 btn_press[i]/btn_release[i] SHALL be registered, high in the same cycle btn_state[i] first shows the new level, low the next cycle.
REQ-020 btn_press[i] and btn_release[i] SHALL never be high together; at most one pulse per channel per tick.
REQ-021 A glitch shorter than STABLE_CNT consecutive ticks SHALL not change btn_state (any agreeing sample restarts the count).
REQ-022 Channels SHALL be fully independent; simultaneous changes on several channels SHALL update in the same cycle.
REQ-023 With STABLE_CNT = 1, a differing sample SHALL be accepted on that tick.
REQ-024 Latency btn_in edge to btn_state change SHALL be 2 clk sync plus STABLE_CNT ticks (max STABLE_CNT+1 clk_deb periods + 4 clk).

Reset
REQ-025 While rst = 1 SHALL force synchronizers, history flop, counters, btn_state, btn_press, btn_release, sample_tick to 0.
REQ-026 Reset mid-count SHALL discard progress; no pulse emitted on or after reset for a pre-reset transition.
REQ-027 If clk_deb is 1 at reset release, exactly one sample_tick SHALL occur 3 clk after release (history resets to 0).
REQ-028 A button already held at reset release SHALL yield btn_state = 1 plus one btn_press after STABLE_CNT ticks.

Verification
REQ-029 Clean press: STABLE_CNT=4, btn_in[0] 0->1 held -> btn_state[0]=1 with one btn_press[0] pulse on the 4th tick after sync; no other channel moves.
REQ-030 Bounce: btn_in[2] toggles 1,0,1,0 on consecutive ticks then holds 1 -> no pulse during bounce; btn_state[2] rises on 4th stable tick.
REQ-031 Release: btn_state[1]=1, btn_in[1] -> 0 held -> one btn_release[1] pulse, btn_state[1]=0 after 4 ticks; btn_press[1] stays 0.
REQ-032 Tick rate: clk_deb period 2^16 clk -> exactly one sample_tick per period, none on falling edges, no state change between ticks.
REQ-033 Reset mid-count: btn_in[3]=1 for 3 ticks, rst pulsed 1 clk -> all outputs 0, counter restarts, press occurs 4 ticks after reset.
REQ-034 Simultaneous: btn_in = 5'b10101 from 0 -> btn_state = 5'b10101 and btn_press = 5'b10101 in the same single cycle.
